max_score: RTL and testbench
============================

Name: max_score

Overview:
- Score-keeping block for the bomb-defuse game.
- Scales the player's raw score by a difficulty multiplier and shows the scaled score as two BCD digits.
- On each button press, the scaled score is compared against the stored high score, and the high score is replaced if the new score is greater.
- Sits between the game FSM (score, multiplier, button) and the seven-segment decoders (BCD digit outputs).

Parameters:
- MAX_VAL, 99, saturation ceiling for scaled and stored scores (two decimal digits).

Ports:
- Clk  input  1  system clock, rising-edge active
- Rst  input  1  asynchronous, active-low reset
- Button  input  1  "commit score" request, synchronous to Clk, level signal; acted on at its rising edge
- PlayerScore  input  8  unsigned binary raw score
- Multiplier  input  2  difficulty multiplier code
- Display10  output  4  BCD tens digit of stored maximum score
- Display1  output  4  BCD ones digit of stored maximum score
- TensScore  output  4  BCD tens digit of current scaled score
- OnesScore  output  4  BCD ones digit of current scaled score

Behaviour:
- Reset (Rst=0, asynchronous): all outputs = 0, stored max = 0, button-history register = 0. Reset dominates every other event.
- Effective multiplier: code 0 -> x1; codes 1, 2, 3 -> x1, x2, x3.
- Scaled score is computed combinationally: S = PlayerScore * effective multiplier, formed in 10 bits.
  - If S > MAX_VAL, then S = MAX_VAL (saturate; no wrap).
- Binary-to-BCD conversion of S (0..99): tens = S/10, ones = S%10. Any method is allowed (double-dabble or compare/subtract), provided it is combinational.
- Current-score outputs:
  - TensScore/OnesScore are registered.
  - On every rising Clk edge they load the BCD of S from the inputs sampled at that edge.
  - Latency 1 clock from input change.
- Button edge detect:
  - Register Button_q <= Button each clock.
  - press = Button & ~Button_q.
  - A held button produces exactly one press.
  - Button high at reset release counts as a press on the first edge where Button_q = 0.
- Max update:
  - On a clock edge where press = 1 and S > stored max (binary compare), stored max <= S.
  - If S <= stored max, there is no change; equal scores do not rewrite.
  - Display10/Display1 are registered BCD of stored max and change on that same edge (1-clock latency from the press edge sampling).
- Without a press, stored max and Display outputs hold indefinitely, regardless of PlayerScore/Multiplier changes.
- Unknown/X inputs are not required to be handled; after reset, outputs stay 0 until inputs are valid and clocked.
- Stored max is only cleared by reset.

Test Plan:
- Reset: Rst=0 mid-operation with max=42 -> all four outputs 0 immediately, without waiting for a clock edge; they stay 0 while Rst=0.
- Basic scale:
  - Stimulus: release reset, PlayerScore=21, Multiplier=2, Button=0.
  - One clock later: TensScore=4, OnesScore=2; Display10=0, Display1=0.
  - Then raise Button: after the next edge, Display10=4, Display1=2.
- Hold/single press:
  - Stimulus: keep Button=1 for 10 clocks while changing PlayerScore to 40, Multiplier=3.
  - Required: TensScore=9, OnesScore=9 (saturated 120 -> 99); Display stays 42.
  - Then release and re-press: Display becomes 99.
- Lower score:
  - Stimulus: max=42; PlayerScore=10, Multiplier=1, press.
  - Required: TensScore=1, OnesScore=0; Display remains 4/2.
  - Then PlayerScore=42, press: Display remains 4/2 (equal, no change).
- Multiplier 0 and boundaries:
  - PlayerScore=9, Multiplier=0 -> 0/9.
  - PlayerScore=0 -> 0/0.
  - PlayerScore=255, Multiplier=1 -> 9/9.
  - PlayerScore=33, Multiplier=3 -> 9/9.
  - PlayerScore=50, Multiplier=2 -> 9/9 (100 saturates).
- Rst asserted on the same edge as a press: max stays 0 and Display stays 0/0.

Source files
------------

// File: rtl/max_score_if.sv
// Signal bundle between the game FSM and the score-keeping block.
// The game side drives the commit button, raw score and difficulty code;
// the score block returns BCD digits for the seven-segment decoders.
interface max_score_if;
  logic       Button;
  logic [7:0] PlayerScore;
  logic [1:0] Multiplier;
  logic [3:0] Display10;
  logic [3:0] Display1;
  logic [3:0] TensScore;
  logic [3:0] OnesScore;

  modport master (
    output Button,
    output PlayerScore,
    output Multiplier,
    input  Display10,
    input  Display1,
    input  TensScore,
    input  OnesScore
  );

  modport slave (
    input  Button,
    input  PlayerScore,
    input  Multiplier,
    output Display10,
    output Display1,
    output TensScore,
    output OnesScore
  );
endinterface

// File: rtl/max_score.sv
// Score keeper for the bomb-defuse game: scales the raw score by the
// difficulty multiplier, saturates at two decimal digits, shows the current
// scaled score as BCD and keeps a high score that is only updated on a
// rising edge of the commit button when the new score is strictly greater.
module max_score #(
  parameter int unsigned MAX_VAL = 99
) (
  input logic        Clk,
  input logic        Rst,
  max_score_if.slave bus
);

  // Ceiling expressed at the width of the scaled product.
  localparam logic [9:0] MAX_VAL_W = 10'(MAX_VAL);

  // Double-dabble conversion of a 0..99 value into two BCD digits.
  // Only the ones digit needs the add-3 correction for values below 100.
  function automatic logic [7:0] bin_to_bcd(input logic [6:0] bin);
    logic [7:0] bcd;
    bcd = 8'd0;
    for (int i = 6; i >= 0; i--) begin
      if (bcd[3:0] >= 4'd5) begin
        bcd[3:0] = bcd[3:0] + 4'd3;
      end else begin
        bcd[3:0] = bcd[3:0];
      end
      bcd = {bcd[6:0], bin[i]};
    end
    return bcd;
  endfunction

  logic [1:0] eff_mult_s;
  logic [9:0] product_s;
  logic [6:0] scaled_s;
  logic       press_s;
  logic [7:0] scaled_bcd_s;
  logic [7:0] max_bcd_s;

  logic       button_d, button_q;
  logic [6:0] max_d,    max_q;
  logic [3:0] tens_d,   tens_q;
  logic [3:0] ones_d,   ones_q;
  logic [3:0] disp10_d, disp10_q;
  logic [3:0] disp1_d,  disp1_q;

  // Map the difficulty code to its multiplier; code 0 behaves as x1.
  always_comb begin
    eff_mult_s = 2'd1;
    case (bus.Multiplier)
      2'd0:    eff_mult_s = 2'd1;
      2'd1:    eff_mult_s = 2'd1;
      2'd2:    eff_mult_s = 2'd2;
      2'd3:    eff_mult_s = 2'd3;
      default: eff_mult_s = 2'd1;
    endcase
  end

  // Scale in 10 bits (255 * 3 = 765 fits) and clamp to the ceiling.
  always_comb begin
    product_s = {2'b00, bus.PlayerScore} * {8'd0, eff_mult_s};
    if (product_s > MAX_VAL_W) begin
      scaled_s = MAX_VAL_W[6:0];
    end else begin
      scaled_s = product_s[6:0];
    end
  end

  // Rising-edge detect of the commit button and high-score update rule.
  always_comb begin
    button_d = bus.Button;
    press_s  = bus.Button & ~button_q;
    if (press_s && (scaled_s > max_q)) begin
      max_d = scaled_s;
    end else begin
      max_d = max_q;
    end
  end

  // BCD digits for the current score and for the next stored maximum, so
  // the display changes on the same edge that updates the maximum.
  always_comb begin
    scaled_bcd_s = bin_to_bcd(scaled_s);
    max_bcd_s    = bin_to_bcd(max_d);
    tens_d       = scaled_bcd_s[7:4];
    ones_d       = scaled_bcd_s[3:0];
    disp10_d     = max_bcd_s[7:4];
    disp1_d      = max_bcd_s[3:0];
  end

  // State and output registers; reset clears everything asynchronously.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      button_q <= 1'b0;
      max_q    <= 7'd0;
      tens_q   <= 4'd0;
      ones_q   <= 4'd0;
      disp10_q <= 4'd0;
      disp1_q  <= 4'd0;
    end else begin
      button_q <= button_d;
      max_q    <= max_d;
      tens_q   <= tens_d;
      ones_q   <= ones_d;
      disp10_q <= disp10_d;
      disp1_q  <= disp1_d;
    end
  end

  assign bus.TensScore = tens_q;
  assign bus.OnesScore = ones_q;
  assign bus.Display10 = disp10_q;
  assign bus.Display1  = disp1_q;

endmodule

// File: tb/tb_max_score.sv
// Self-checking bench for max_score: a reference model pushes the expected
// digits for each clock edge into a queue; each scenario task pops and
// compares after the edge.
module tb_max_score;

  logic Clk;
  logic Rst;

  max_score_if bus ();

  max_score #(.MAX_VAL(99)) dut (
    .Clk (Clk),
    .Rst (Rst),
    .bus (bus)
  );

  typedef struct {
    logic [3:0] tens;
    logic [3:0] ones;
    logic [3:0] d10;
    logic [3:0] d1;
  } exp_t;

  typedef struct {
    logic       rst;
    logic       b;
    logic [7:0] ps;
    logic [1:0] m;
  } vec_t;

  exp_t sb_q[$];
  int   model_max;
  logic model_bq;
  int   vectors;
  int   miscompares;

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  // Reference model for one clock edge with the given inputs.
  task automatic push_expect(input logic rst_v, input logic b, input logic [7:0] ps, input logic [1:0] m);
    exp_t e;
    int   eff;
    int   s;
    if (!rst_v) begin
      model_max = 0;
      model_bq  = 1'b0;
      e.tens = 4'd0; e.ones = 4'd0; e.d10 = 4'd0; e.d1 = 4'd0;
    end else begin
      eff = (m == 2'd0) ? 1 : int'(m);
      s   = int'(ps) * eff;
      if (s > 99) s = 99;
      if (b && !model_bq && (s > model_max)) model_max = s;
      model_bq = b;
      e.tens = 4'(s / 10);
      e.ones = 4'(s % 10);
      e.d10  = 4'(model_max / 10);
      e.d1   = 4'(model_max % 10);
    end
    sb_q.push_back(e);
  endtask

  // Apply one vector at the falling edge, then wait until just after the rising edge.
  task automatic drive(input vec_t v);
    @(negedge Clk);
    Rst             = v.rst;
    bus.Button      = v.b;
    bus.PlayerScore = v.ps;
    bus.Multiplier  = v.m;
    push_expect(v.rst, v.b, v.ps, v.m);
    @(posedge Clk);
    #1;
  endtask

  task automatic test_reset;
    Rst = 1'b0; bus.Button = 1'b0; bus.PlayerScore = 8'd77; bus.Multiplier = 2'd1;
    model_max = 0; model_bq = 1'b0;
    #3;
    vectors++;
    if ({bus.TensScore, bus.OnesScore, bus.Display10, bus.Display1} !== 16'h0000) begin
      miscompares++;
      $display("FAIL reset_init: got %h%h/%h%h expected 00/00", bus.TensScore, bus.OnesScore, bus.Display10, bus.Display1);
    end
    drive('{1'b0, 1'b1, 8'd77, 2'd1});
    vectors++;
    if (sb_q.size() == 0) begin
      miscompares++; $display("FAIL reset_clk: scoreboard empty");
    end else begin
      exp_t e;
      e = sb_q.pop_front();
      if ({bus.TensScore, bus.OnesScore, bus.Display10, bus.Display1} !== {e.tens, e.ones, e.d10, e.d1}) begin
        miscompares++;
        $display("FAIL reset_clk: got %h%h/%h%h expected %h%h/%h%h", bus.TensScore, bus.OnesScore,
                 bus.Display10, bus.Display1, e.tens, e.ones, e.d10, e.d1);
      end
    end
  endtask

  task automatic test_basic_scale;
    vec_t v[3];
    v[0] = '{1'b1, 1'b0, 8'd21, 2'd2};
    v[1] = '{1'b1, 1'b0, 8'd21, 2'd2};
    v[2] = '{1'b1, 1'b1, 8'd21, 2'd2};
    for (int i = 0; i < 3; i++) begin
      drive(v[i]);
      vectors++;
      if (sb_q.size() == 0) begin
        miscompares++; $display("FAIL basic[%0d]: scoreboard empty", i);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        if ({bus.TensScore, bus.OnesScore, bus.Display10, bus.Display1} !== {e.tens, e.ones, e.d10, e.d1}) begin
          miscompares++;
          $display("FAIL basic[%0d]: got %h%h/%h%h expected %h%h/%h%h", i, bus.TensScore, bus.OnesScore,
                   bus.Display10, bus.Display1, e.tens, e.ones, e.d10, e.d1);
        end
      end
    end
  endtask

  task automatic test_lower_score;
    vec_t v[6];
    v[0] = '{1'b1, 1'b0, 8'd10, 2'd1};
    v[1] = '{1'b1, 1'b1, 8'd10, 2'd1};
    v[2] = '{1'b1, 1'b0, 8'd10, 2'd1};
    v[3] = '{1'b1, 1'b1, 8'd42, 2'd1};
    v[4] = '{1'b1, 1'b0, 8'd42, 2'd1};
    v[5] = '{1'b1, 1'b1, 8'd41, 2'd0};
    for (int i = 0; i < 6; i++) begin
      drive(v[i]);
      vectors++;
      if (sb_q.size() == 0) begin
        miscompares++; $display("FAIL lower[%0d]: scoreboard empty", i);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        if ({bus.TensScore, bus.OnesScore, bus.Display10, bus.Display1} !== {e.tens, e.ones, e.d10, e.d1}) begin
          miscompares++;
          $display("FAIL lower[%0d]: got %h%h/%h%h expected %h%h/%h%h", i, bus.TensScore, bus.OnesScore,
                   bus.Display10, bus.Display1, e.tens, e.ones, e.d10, e.d1);
        end
      end
    end
  endtask

  task automatic test_reset_mid;
    vec_t v[3];
    // Ensure a non-zero stored maximum (42) before reset is asserted.
    drive('{1'b1, 1'b0, 8'd21, 2'd2});
    void'(sb_q.pop_front());
    #2;
    Rst = 1'b0;
    model_max = 0; model_bq = 1'b0;
    #1;
    vectors++;
    if ({bus.TensScore, bus.OnesScore, bus.Display10, bus.Display1} !== 16'h0000) begin
      miscompares++;
      $display("FAIL reset_async: got %h%h/%h%h expected 00/00", bus.TensScore, bus.OnesScore, bus.Display10, bus.Display1);
    end
    v[0] = '{1'b0, 1'b1, 8'd60, 2'd1};
    v[1] = '{1'b0, 1'b0, 8'd60, 2'd1};
    v[2] = '{1'b1, 1'b0, 8'd60, 2'd1};
    for (int i = 0; i < 3; i++) begin
      drive(v[i]);
      vectors++;
      if (sb_q.size() == 0) begin
        miscompares++; $display("FAIL reset_hold[%0d]: scoreboard empty", i);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        if ({bus.TensScore, bus.OnesScore, bus.Display10, bus.Display1} !== {e.tens, e.ones, e.d10, e.d1}) begin
          miscompares++;
          $display("FAIL reset_hold[%0d]: got %h%h/%h%h expected %h%h/%h%h", i, bus.TensScore, bus.OnesScore,
                   bus.Display10, bus.Display1, e.tens, e.ones, e.d10, e.d1);
        end
      end
    end
  endtask

  task automatic test_hold_press;
    vec_t v[14];
    v[0] = '{1'b1, 1'b1, 8'd21, 2'd2};
    for (int i = 1; i <= 10; i++) v[i] = '{1'b1, 1'b1, 8'd40, 2'd3};
    v[11] = '{1'b1, 1'b0, 8'd40, 2'd3};
    v[12] = '{1'b1, 1'b1, 8'd40, 2'd3};
    v[13] = '{1'b1, 1'b0, 8'd5,  2'd1};
    for (int i = 0; i < 14; i++) begin
      drive(v[i]);
      vectors++;
      if (sb_q.size() == 0) begin
        miscompares++; $display("FAIL hold[%0d]: scoreboard empty", i);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        if ({bus.TensScore, bus.OnesScore, bus.Display10, bus.Display1} !== {e.tens, e.ones, e.d10, e.d1}) begin
          miscompares++;
          $display("FAIL hold[%0d]: got %h%h/%h%h expected %h%h/%h%h", i, bus.TensScore, bus.OnesScore,
                   bus.Display10, bus.Display1, e.tens, e.ones, e.d10, e.d1);
        end
      end
    end
  endtask

  task automatic test_boundaries;
    vec_t v[9];
    v[0] = '{1'b1, 1'b0, 8'd9,   2'd0};
    v[1] = '{1'b1, 1'b0, 8'd0,   2'd0};
    v[2] = '{1'b1, 1'b0, 8'd255, 2'd1};
    v[3] = '{1'b1, 1'b0, 8'd33,  2'd3};
    v[4] = '{1'b1, 1'b0, 8'd50,  2'd2};
    v[5] = '{1'b1, 1'b0, 8'd49,  2'd2};
    v[6] = '{1'b1, 1'b0, 8'd99,  2'd1};
    v[7] = '{1'b1, 1'b0, 8'd255, 2'd3};
    v[8] = '{1'b1, 1'b0, 8'd17,  2'd3};
    for (int i = 0; i < 9; i++) begin
      drive(v[i]);
      vectors++;
      if (sb_q.size() == 0) begin
        miscompares++; $display("FAIL bound[%0d]: scoreboard empty", i);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        if ({bus.TensScore, bus.OnesScore, bus.Display10, bus.Display1} !== {e.tens, e.ones, e.d10, e.d1}) begin
          miscompares++;
          $display("FAIL bound[%0d]: got %h%h/%h%h expected %h%h/%h%h", i, bus.TensScore, bus.OnesScore,
                   bus.Display10, bus.Display1, e.tens, e.ones, e.d10, e.d1);
        end
      end
    end
  endtask

  // Press coincides with reset; then a button still high at release counts as a press.
  task automatic test_reset_press;
    vec_t v[6];
    v[0] = '{1'b1, 1'b0, 8'd30, 2'd1};
    v[1] = '{1'b0, 1'b1, 8'd30, 2'd1};
    v[2] = '{1'b1, 1'b1, 8'd30, 2'd1};
    v[3] = '{1'b1, 1'b1, 8'd31, 2'd1};
    v[4] = '{1'b1, 1'b0, 8'd31, 2'd1};
    v[5] = '{1'b1, 1'b1, 8'd12, 2'd2};
    for (int i = 0; i < 6; i++) begin
      drive(v[i]);
      vectors++;
      if (sb_q.size() == 0) begin
        miscompares++; $display("FAIL rst_press[%0d]: scoreboard empty", i);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        if ({bus.TensScore, bus.OnesScore, bus.Display10, bus.Display1} !== {e.tens, e.ones, e.d10, e.d1}) begin
          miscompares++;
          $display("FAIL rst_press[%0d]: got %h%h/%h%h expected %h%h/%h%h", i, bus.TensScore, bus.OnesScore,
                   bus.Display10, bus.Display1, e.tens, e.ones, e.d10, e.d1);
        end
      end
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    test_reset();
    test_basic_scale();
    test_lower_score();
    test_reset_mid();
    test_hold_press();
    test_boundaries();
    test_reset_press();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
